s12379_timing_ctrl: RTL and testbench

S12379_TIMING_CTRL -- requirements
Module: s12379_timing_ctrl

---
 rtl/s12379_timing_ctrl.sv | 170 +++++++++++++++++
 tb/tb_s12379_timing_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s12379_timing_ctrl.sv
// CCD line timing controller.
// Produces the transfer gate (sh), the complementary shift clocks (f1/f2) and the
// per-pixel reset (rs) for one line of DUMMY_NUM + SAMP_NUM pixels. A line can
// optionally be padded to a programmed period, and lines can repeat back to back.
//
// Ports:
//   sys_clk      system clock; the only clock in the block
//   sys_rst_n    synchronous active-low reset
//   start        one-cycle request to begin a line (ignored while busy)
//   cont_mode    1 = repeat lines back to back, sampled on the line-end cycle
//   line_period  line period in sys_clk cycles, latched at every line start
//   sh           transfer gate pulse
//   f1, f2       shift clocks, f1 = ~f2
//   rs           reset gate, idle high, low once per readout pixel
//   busy         high while a line is in progress
//   line_start   pulse on the first cycle of a line
//   line_done    pulse on the last cycle of a line
//   line_cnt     completed line count, wraps at 16 bits
module s12379_timing_ctrl #(
    parameter int unsigned PIX_HALF     = 5,
    parameter int unsigned SAMP_NUM     = 2048,
    parameter int unsigned DUMMY_NUM    = 10,
    parameter int unsigned SH_WIDTH     = 20,
    parameter int unsigned SH_GUARD     = 5,
    parameter int unsigned RS_LOW_WIDTH = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        cont_mode,
    input  logic [23:0] line_period,
    output logic        sh,
    output logic        f1,
    output logic        f2,
    output logic        rs,
    output logic        busy,
    output logic        line_start,
    output logic        line_done,
    output logic [15:0] line_cnt
);

    localparam int unsigned PixPeriod = 2 * PIX_HALF;
    localparam int unsigned SegLen    = 2 * SH_GUARD + SH_WIDTH;
    localparam int unsigned PixTotal  = DUMMY_NUM + SAMP_NUM;
    localparam int unsigned NatLen    = SegLen + PixTotal * PixPeriod;

    localparam logic [15:0] SegLast   = 16'(SegLen - 1);
    localparam logic [15:0] PhaseLast = 16'(PixPeriod - 1);
    localparam logic [15:0] PixLast   = 16'(PixTotal - 1);
    localparam logic [15:0] ShOn      = 16'(SH_GUARD);
    localparam logic [15:0] ShOff     = 16'(SH_GUARD + SH_WIDTH);
    localparam logic [15:0] HalfP     = 16'(PIX_HALF);
    localparam logic [15:0] RsLast    = 16'(RS_LOW_WIDTH);
    localparam logic [31:0] NatLen32  = 32'(NatLen);

    typedef enum logic [1:0] {StIdle, StSh, StReadout, StWait} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;           // segment cycle in StSh, pixel phase otherwise
    logic [15:0] pix_q, pix_d;
    logic [23:0] line_cyc_q, line_cyc_d; // cycles since line_start
    logic [23:0] period_q, period_d;

    logic pad_line;
    logic in_pix;
    logic sh_d, f2_d, rs_d, done_d;

    // Next-state logic. line_done marks the current cycle as the last of the line,
    // so the line-end decision is taken from it rather than recomputed.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pix_d      = pix_q;
        line_cyc_d = line_cyc_q;
        period_d   = period_q;
        if (line_done) begin
            cnt_d      = '0;
            pix_d      = '0;
            line_cyc_d = '0;
            if (cont_mode) begin
                state_d  = StSh;
                period_d = line_period;
            end else begin
                state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d    = StSh;
                        cnt_d      = '0;
                        pix_d      = '0;
                        line_cyc_d = '0;
                        period_d   = line_period;
                    end
                end
                StSh: begin
                    line_cyc_d = line_cyc_q + 24'd1;
                    if (cnt_q == SegLast) begin
                        state_d = StReadout;
                        cnt_d   = '0;
                        pix_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StReadout: begin
                    line_cyc_d = line_cyc_q + 24'd1;
                    if (cnt_q == PhaseLast) begin
                        cnt_d = '0;
                        // Only reached when padding applies; otherwise line_done ends the line.
                        if (pix_q == PixLast) state_d = StWait;
                        else                  pix_d   = pix_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StWait: begin
                    line_cyc_d = line_cyc_q + 24'd1;
                    cnt_d      = (cnt_q == PhaseLast) ? 16'd0 : cnt_q + 16'd1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are derived from the next-state values so they can be registered
    // and still line up with the state they describe.
    assign pad_line = {8'd0, period_d} > NatLen32;
    assign in_pix   = (state_d == StReadout) || (state_d == StWait);
    assign sh_d     = (state_d == StSh) && (cnt_d >= ShOn) && (cnt_d < ShOff);
    assign f2_d     = in_pix && (cnt_d < HalfP);
    assign rs_d     = !((state_d == StReadout) && (cnt_d >= 16'd1) && (cnt_d <= RsLast));
    assign done_d   = ((state_d == StReadout) && (pix_d == PixLast) && (cnt_d == PhaseLast)
                       && !pad_line)
                    || ((state_d == StWait) && (line_cyc_d == period_d - 24'd1));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pix_q      <= '0;
            line_cyc_q <= '0;
            period_q   <= '0;
            sh         <= 1'b0;
            f2         <= 1'b0;
            f1         <= 1'b1;
            rs         <= 1'b1;
            busy       <= 1'b0;
            line_start <= 1'b0;
            line_done  <= 1'b0;
            line_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pix_q      <= pix_d;
            line_cyc_q <= line_cyc_d;
            period_q   <= period_d;
            sh         <= sh_d;
            f2         <= f2_d;
            f1         <= ~f2_d;
            rs         <= rs_d;
            busy       <= (state_d != StIdle);
            line_start <= (state_d == StSh) && (cnt_d == 16'd0);
            line_done  <= done_d;
            if (done_d) line_cnt <= line_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_s12379_timing_ctrl.sv
// Scoreboard bench for s12379_timing_ctrl with reduced line geometry.
module tb_s12379_timing_ctrl;

    localparam int PH   = 3;
    localparam int SN   = 8;
    localparam int DN   = 2;
    localparam int SW   = 4;
    localparam int SG   = 2;
    localparam int RL   = 2;
    localparam int P    = 2 * PH;
    localparam int SEG  = 2 * SG + SW;
    localparam int NLEN = SEG + (DN + SN) * P;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic        cont_mode;
    logic [23:0] line_period;
    logic        sh, f1, f2, rs, busy, line_start, line_done;
    logic [15:0] line_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        int len;
        bit cont;
    } line_t;

    line_t exp_q[$];
    bit    mon_en      = 1'b0;
    bit    rst_pending = 1'b0;

    s12379_timing_ctrl #(
        .PIX_HALF     (PH),
        .SAMP_NUM     (SN),
        .DUMMY_NUM    (DN),
        .SH_WIDTH     (SW),
        .SH_GUARD     (SG),
        .RS_LOW_WIDTH (RL)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start       (start),
        .cont_mode   (cont_mode),
        .line_period (line_period),
        .sh          (sh),
        .f1          (f1),
        .f2          (f2),
        .rs          (rs),
        .busy        (busy),
        .line_start  (line_start),
        .line_done   (line_done),
        .line_cnt    (line_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int len_of(input int per);
        return (per > NLEN) ? per : NLEN;
    endfunction

    // Expected {sh, f2, rs} at cycle kk of a line, straight from the timing rules.
    function automatic logic [2:0] model_out(input int kk);
        logic s, f, r;
        int   ph;
        s = 1'b0;
        f = 1'b0;
        r = 1'b1;
        if (kk < SEG) begin
            s = (kk >= SG) && (kk < SG + SW);
        end else if (kk < NLEN) begin
            ph = (kk - SEG) % P;
            f  = ph < PH;
            r  = !(ph >= 1 && ph <= RL);
        end else begin
            ph = (kk - NLEN) % P;
            f  = ph < PH;
        end
        return {s, f, r};
    endfunction

    // Monitor / scoreboard
    int          k = 0;
    bit          in_line = 1'b0;
    line_t       cur;
    logic [15:0] done_lines = '0;

    always @(negedge sys_clk) begin : mon
        bit          exp_ls, was_in, exp_done;
        logic [2:0]  m;
        exp_ls = 1'b0;
        if (mon_en) begin
            if (rst_pending) begin
                in_line = 1'b0;
                exp_q.delete();
                done_lines = '0;
            end else if (in_line) begin
                k++;
                if (k >= cur.len) begin
                    in_line = 1'b0;
                    exp_ls  = cur.cont;
                end
            end
            was_in = in_line;
            if (was_in) check("no_line_start_midline", line_start, 0);
            if (!was_in && exp_q.size() == 0 && !exp_ls)
                check("no_unrequested_line_start", line_start, 0);
            if (exp_ls) check("cont_restart", line_start, 1);
            if (line_start && !was_in && exp_q.size() > 0) begin
                cur     = exp_q.pop_front();
                k       = 0;
                in_line = 1'b1;
            end
            m        = in_line ? model_out(k) : 3'b001;
            exp_done = in_line && (k == cur.len - 1);
            if (exp_done) done_lines = done_lines + 16'd1;
            check("sh", sh, m[2]);
            check("f2", f2, m[1]);
            check("f1", f1, !m[1]);
            check("rs", rs, m[0]);
            check("busy", busy, in_line);
            check("line_done", line_done, exp_done);
            check("line_cnt", line_cnt, done_lines);
        end
        rst_pending = !sys_rst_n;
    end

    function automatic int rand_period();
        int sel;
        sel = int'($urandom_range(0, 4));
        case (sel)
            0:       return 0;
            1:       return int'($urandom_range(1, NLEN));
            2:       return NLEN;
            3:       return NLEN + 1;
            default: return int'($urandom_range(NLEN + 2, NLEN + 40));
        endcase
    endfunction

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge sys_clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", busy, 0);
    endtask

    task automatic wait_ls(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge sys_clk);
            if (line_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("line_start_timeout", line_start, 1);
    endtask

    task automatic issue_start(input int per, input bit cont);
        line_t r;
        @(posedge sys_clk);
        #1;
        line_period = 24'(per);
        start       = 1'b1;
        cont_mode   = cont;
        r.len  = len_of(per);
        r.cont = cont;
        exp_q.push_back(r);
        @(posedge sys_clk);
        #1;
        start       = 1'b0;
        line_period = 24'($urandom);
        @(negedge sys_clk);
        check("start_latency", line_start, 1);
    endtask

    task automatic run_single(input int per);
        issue_start(per, 1'b0);
        repeat ($urandom_range(3, 30)) @(posedge sys_clk);
        #1;
        start     = 1'b1;  // stray start while busy, plus a transient cont request
        cont_mode = 1'b1;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        @(posedge sys_clk);
        #1;
        cont_mode = 1'b0;
        wait_idle(len_of(per) + 10);
    endtask

    task automatic run_cont(input int per1, input int per2, input int per3);
        line_t r;
        issue_start(per1, 1'b1);
        @(posedge sys_clk);
        #1;
        line_period = 24'(per2);
        r.len  = len_of(per2);
        r.cont = 1'b1;
        exp_q.push_back(r);
        wait_ls(300);
        @(posedge sys_clk);
        #1;
        line_period = 24'(per3);
        r.len  = len_of(per3);
        r.cont = 1'b0;
        exp_q.push_back(r);
        wait_ls(300);
        repeat ($urandom_range(2, 40)) @(posedge sys_clk);
        #1;
        cont_mode = 1'b0;
        start     = 1'b1;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        wait_idle(len_of(per3) + 10);
    endtask

    task automatic run_reset(input int per);
        issue_start(per, 1'b0);
        repeat (SEG + 5 * P) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        start     = 1'b1;  // must be ignored under reset
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        start     = 1'b0;
        @(negedge sys_clk);
        check("reset_busy", busy, 0);
        check("reset_line_cnt", line_cnt, 0);
        repeat (3) @(posedge sys_clk);
    endtask

    initial begin : watchdog
        #500000;
        err_cnt++;
        $display("FAIL watchdog at %0t: got running, expected finished", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin : stim
        sys_rst_n   = 1'b0;
        start       = 1'b1;
        cont_mode   = 1'b0;
        line_period = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        mon_en = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        start     = 1'b0;
        repeat (4) @(posedge sys_clk);

        run_single(0);
        run_single(NLEN);
        run_single(NLEN + 1);
        run_single(NLEN + 30);
        for (int i = 0; i < 10; i++) run_single(rand_period());
        run_cont(NLEN + 30, NLEN + 30, NLEN + 30);
        run_cont(10, 10, 10);
        for (int i = 0; i < 4; i++) run_cont(rand_period(), rand_period(), rand_period());
        run_reset(rand_period());
        run_single(0);
        run_reset(NLEN + 20);
        run_single(rand_period());

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
